// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring shift-subtract divider for DIV/DIVU with EX stall request.
// result_o = {remainder, quotient}; one quotient bit per cycle, sign fix-up on entry to END.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dq, dvs, rem, rem_n, dq_n, q_fix, r_fix, abs1, abs2;
  logic [WIDTH:0] shifted, diff;
  logic neg_q, neg_r, qbit, last;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;
  // dq holds the unconsumed dividend bits in its top and the growing quotient in its bottom
  always_comb begin
    abs1 = signed_div_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
    abs2 = signed_div_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
    shifted = {rem, dq[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    qbit = ~diff[WIDTH];
    rem_n = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dq_n = {dq[WIDTH-2:0], qbit};
    q_fix = neg_q ? -dq_n : dq_n;
    r_fix = neg_r ? -rem_n : rem_n;
    last = cnt == CW'(WIDTH - 1);
    state_n = state;
    if (annul_i) state_n = FREE;
    else
      case (state)
        FREE:    state_n = !start_i ? FREE : opdata2_i == '0 ? BYZERO : ON;
        BYZERO:  state_n = start_i ? END : FREE;
        ON:      state_n = !start_i ? FREE : last ? END : ON;
        default: state_n = start_i ? END : FREE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
      cnt <= '0;
      dq <= '0;
      dvs <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      state <= state_n;
      ready_o <= state_n == END;
      result_o <= state_n != END ? '0 : state == ON ? {r_fix, q_fix} : result_o;
      if (state == FREE && state_n == ON) begin
        dq <= abs1;
        dvs <= abs2;
        rem <= '0;
        cnt <= '0;
        neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_r <= signed_div_i & opdata1_i[WIDTH-1];
      end else if (state == ON) begin
        dq <= dq_n;
        rem <= rem_n;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard-driven bench for div_unit covering latency, signs, overflow, zero, annul and reset.
module tb_div_unit;
  logic clk = 0, rst = 0, start_i = 0, signed_div_i = 0, annul_i = 0;
  logic [31:0] opdata1_i = 0, opdata2_i = 0;
  logic [63:0] result_o;
  logic ready_o, stallreq_o;
  logic [63:0] sb[$];
  int tests = 0, fails = 0;
  logic [31:0] ta[5] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic [31:0] tb_[5] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic ts[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] te[5] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'hFFFFFFFD}, {32'h1, 32'h7FFFFFFF},
                         {32'h0, 32'h80000000}, {32'h80000000, 32'h0}};

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] exp);
    @(posedge clk); #1;
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1; sb.push_back(exp);
  endtask

  // operands are scrambled after the accept cycle to show only latched copies matter
  task automatic wait_ready(output int cyc, output int stall);
    cyc = 0; stall = 0;
    @(negedge clk);
    while (!ready_o && cyc < 100) begin
      if (stallreq_o) stall++;
      if (cyc > 0) begin opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~signed_div_i; end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    @(posedge clk); #1 start_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
      fails++; $display("FAIL reset: result=%h ready=%b stall=%b, want 0/0/0", result_o, ready_o, stallreq_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_basic();
    int cyc, stall;
    logic [63:0] exp;
    issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (cyc !== 33 || stall !== 33) begin
      fails++; $display("FAIL basic_latency: cycles=%0d stall=%0d, want 33/33", cyc, stall);
    end
    tests++;
    if (result_o !== exp || stallreq_o !== 1'b0) begin
      fails++; $display("FAIL basic_result: result=%h stall=%b, want %h/0", result_o, stallreq_o, exp);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (ready_o !== 1'b1 || result_o !== exp || stallreq_o !== 1'b0) begin
        fails++; $display("FAIL end_hold: ready=%b result=%h stall=%b, want 1/%h/0", ready_o, result_o, stallreq_o, exp);
      end
    end
    finish_op();
    tests++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      fails++; $display("FAIL release: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int cyc, stall;
    logic [63:0] exp;
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb_[i], ts[i], te[i]);
      wait_ready(cyc, stall);
      exp = sb.pop_front();
      tests++;
      if (cyc !== 33 || result_o !== exp) begin
        fails++; $display("FAIL signed_%0d: cycles=%0d result=%h, want 33/%h", i, cyc, result_o, exp);
      end
      finish_op();
    end
  endtask

  task automatic test_div_zero();
    int cyc, stall;
    logic [63:0] exp;
    issue(32'h1234, 32'd0, 1'b1, 64'd0);
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (cyc !== 2 || result_o !== exp || stallreq_o !== 1'b0) begin
      fails++; $display("FAIL div_zero: cycles=%0d result=%h stall=%b, want 2/%h/0", cyc, result_o, stallreq_o, exp);
    end
    finish_op();
  endtask

  task automatic test_annul();
    int cyc, stall;
    logic seen = 0;
    logic [63:0] exp;
    issue(32'd12345, 32'd7, 1'b0, model(32'd12345, 32'd7, 1'b0));
    repeat (11) @(posedge clk);
    #1 annul_i = 1;
    @(negedge clk);
    tests++;
    if (stallreq_o !== 1'b0) begin
      fails++; $display("FAIL annul_stall: stall=%b, want 0", stallreq_o);
    end
    @(posedge clk); #1 annul_i = 0; start_i = 0;
    void'(sb.pop_front());
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1; end
    tests++;
    if (seen !== 1'b0 || result_o !== 64'd0) begin
      fails++; $display("FAIL annul_discard: ready_seen=%b result=%h, want 0/0", seen, result_o);
    end
    issue(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (cyc !== 33 || result_o !== exp) begin
      fails++; $display("FAIL after_annul: cycles=%0d result=%h, want 33/%h", cyc, result_o, exp);
    end
    finish_op();
  endtask

  task automatic test_abandon();
    int cyc, stall;
    logic seen = 0;
    logic [63:0] exp;
    issue(32'd500, 32'd5, 1'b0, {32'd0, 32'd100});
    repeat (5) @(posedge clk);
    #1 start_i = 0;
    void'(sb.pop_front());
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1; end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL abandon: ready_seen=%b, want 0", seen);
    end
    issue(32'd50, 32'd5, 1'b0, {32'd0, 32'd10});
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (cyc !== 33 || result_o !== exp) begin
      fails++; $display("FAIL after_abandon: cycles=%0d result=%h, want 33/%h", cyc, result_o, exp);
    end
    finish_op();
  endtask

  task automatic test_mid_reset();
    int cyc, stall;
    logic [63:0] exp;
    issue(32'd1000000, 32'd3, 1'b0, model(32'd1000000, 32'd3, 1'b0));
    repeat (21) @(posedge clk);
    #3 rst = 0; start_i = 0;
    #1;
    tests++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      fails++; $display("FAIL reset_on: ready=%b result=%h stall=%b, want 0/0/0", ready_o, result_o, stallreq_o);
    end
    void'(sb.pop_front());
    @(posedge clk); #1 rst = 1;
    issue(32'd77, 32'd5, 1'b0, {32'd2, 32'd15});
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (result_o !== exp) begin
      fails++; $display("FAIL pre_reset_end: result=%h, want %h", result_o, exp);
    end
    @(posedge clk); #3 rst = 0;
    #1;
    tests++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      fails++; $display("FAIL reset_end_async: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    start_i = 0;
    @(posedge clk); #1 rst = 1;
    issue(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100});
    wait_ready(cyc, stall);
    exp = sb.pop_front();
    tests++;
    if (cyc !== 33 || result_o !== exp) begin
      fails++; $display("FAIL after_reset: cycles=%0d result=%h, want 33/%h", cyc, result_o, exp);
    end
    finish_op();
  endtask

  task automatic test_random();
    int cyc, stall;
    logic [31:0] a, b;
    logic s;
    logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      if (i[1]) a = -a;
      s = i[0];
      issue(a, b, s, model(a, b, s));
      wait_ready(cyc, stall);
      exp = sb.pop_front();
      tests++;
      if (cyc !== 33 || result_o !== exp) begin
        fails++; $display("FAIL random_%0d: %h/%h s=%b cycles=%0d result=%h, want 33/%h", i, a, b, s, cyc, result_o, exp);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_abandon();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
